// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the Booth multiplier datapath.
//   DIR_RIGHT / DIR_LEFT : values of the shift-register 'dir' input.
//   shift_mode_t         : shift modes the controller can request.
//   decode_shift_mode()  : maps dir/arith onto a shift mode.
// Optional feature macro used by the consumers of this package:
//   SHREG_DUAL_SHIFT_EN (radix-4 double shift in booth_shreg).
package booth_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        MODE_HOLD        = 2'd0,
        MODE_RIGHT_LOG   = 2'd1,
        MODE_RIGHT_ARITH = 2'd2,
        MODE_LEFT        = 2'd3
    } shift_mode_t;

    // A left shift never sign-extends, so arith only matters going right.
    function automatic shift_mode_t decode_shift_mode(input logic dir, input logic arith);
        if (dir == DIR_LEFT) begin
            return MODE_LEFT;
        end
        return arith ? MODE_RIGHT_ARITH : MODE_RIGHT_LOG;
    endfunction

endpackage

// File: rtl/booth_shcnt.sv
// booth_shcnt
// Saturating shift counter: counts shift positions since the last clear
// and stops at W.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear (highest priority)
//   inc  : add one position
//   inc2 : add two positions (only with SHREG_DUAL_SHIFT_EN), wins over inc
//   cnt  : positions shifted, saturating at W
//   done : cnt == W
// Parameters: W (saturation value), CNT_W (counter width, 2**CNT_W > W).
module booth_shcnt #(
    parameter int W     = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
`ifdef SHREG_DUAL_SHIFT_EN
    input  logic             inc2,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(W);

    logic [CNT_W:0]   cnt_wide;
    logic [CNT_W:0]   step_sum;
    logic [CNT_W-1:0] cnt_next;

    // The sum is one bit wider so cnt+2 near the top cannot wrap before
    // the saturation compare sees it.
    always_comb begin
        cnt_wide = {1'b0, cnt};
        step_sum = cnt_wide;
`ifdef SHREG_DUAL_SHIFT_EN
        if (inc2) begin
            step_sum = cnt_wide + (CNT_W + 1)'(2);
        end else if (inc) begin
            step_sum = cnt_wide + (CNT_W + 1)'(1);
        end
`else
        if (inc) begin
            step_sum = cnt_wide + (CNT_W + 1)'(1);
        end
`endif
        cnt_next = (step_sum > LIMIT) ? LIMIT[CNT_W-1:0] : step_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign done = (cnt == LIMIT[CNT_W-1:0]);

endmodule

// File: rtl/booth_shreg.sv
// booth_shreg
// Serial/parallel shift register for the Booth multiplier datapath.
// Supports logical right, arithmetic right and left shifts, plus a
// saturating shift counter whose done flag marks the end of W iterations.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   init   : synchronous clear of register and counter (highest priority)
//   ld     : parallel load of parin, clears counter
//   sh     : shift one position
//   dir    : 0 = right (toward bit 0), 1 = left
//   arith  : right shifts replicate the MSB, serin ignored
//   serin  : fill bit for logical shifts
//   parin  : parallel load data
//   parout : register contents
//   serout : bit leaving on the next single shift
//   cnt    : shifts since last init/ld, saturating at W
//   done   : cnt == W
// Optional macro SHREG_DUAL_SHIFT_EN adds sh2/serin2/serout2 for a
// radix-4 double shift (requires W >= 3).
module booth_shreg #(
    parameter int W     = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             ld,
    input  logic             sh,
    input  logic             dir,
    input  logic             arith,
    input  logic             serin,
    input  logic [W-1:0]     parin,
`ifdef SHREG_DUAL_SHIFT_EN
    input  logic             sh2,
    input  logic [1:0]       serin2,
    output logic [1:0]       serout2,
`endif
    output logic [W-1:0]     parout,
    output logic             serout,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    import booth_pkg::*;

    shift_mode_t mode;
    logic [W-1:0] shifted1;
    logic [W-1:0] next_data;
`ifdef SHREG_DUAL_SHIFT_EN
    logic [W-1:0] shifted2;
`endif

    // Candidate shifted values; the register block below picks between
    // them and the load/clear paths.
    always_comb begin
        mode     = decode_shift_mode(dir, arith);
        shifted1 = parout;
        case (mode)
            MODE_RIGHT_LOG:   shifted1 = {serin, parout[W-1:1]};
            MODE_RIGHT_ARITH: shifted1 = {parout[W-1], parout[W-1:1]};
            MODE_LEFT:        shifted1 = {parout[W-2:0], serin};
            default:          shifted1 = parout;
        endcase
`ifdef SHREG_DUAL_SHIFT_EN
        shifted2 = parout;
        case (mode)
            MODE_RIGHT_LOG:   shifted2 = {serin2, parout[W-1:2]};
            MODE_RIGHT_ARITH: shifted2 = {{2{parout[W-1]}}, parout[W-1:2]};
            MODE_LEFT:        shifted2 = {parout[W-3:0], serin2};
            default:          shifted2 = parout;
        endcase
        next_data = sh2 ? shifted2 : (sh ? shifted1 : parout);
`else
        next_data = sh ? shifted1 : parout;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parout <= '0;
        end else if (init) begin
            parout <= '0;
        end else if (ld) begin
            parout <= parin;
        end else begin
            parout <= next_data;
        end
    end

    // The outgoing bit follows dir combinationally, so the controller must
    // keep dir stable while it samples serout.
    assign serout = (dir == DIR_LEFT) ? parout[W-1] : parout[0];
`ifdef SHREG_DUAL_SHIFT_EN
    assign serout2 = (dir == DIR_LEFT) ? parout[W-1:W-2] : parout[1:0];
`endif

    booth_shcnt #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_shcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (init | ld),
        .inc  (sh),
`ifdef SHREG_DUAL_SHIFT_EN
        .inc2 (sh2),
`endif
        .cnt  (cnt),
        .done (done)
    );

endmodule

// File: tb/tb_booth_shreg.sv
// tb_booth_shreg
// Self-checking bench for booth_shreg (W=6, CNT_W=3): directed scenarios
// with literal expectations, then random traffic compared every cycle
// against an arithmetic reference model.
module tb_booth_shreg;

    localparam int W     = 6;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             init;
    logic             ld;
    logic             sh;
    logic             dir;
    logic             arith;
    logic             serin;
    logic [W-1:0]     parin;
    logic [W-1:0]     parout;
    logic             serout;
    logic [CNT_W-1:0] cnt;
    logic             done;
`ifdef SHREG_DUAL_SHIFT_EN
    logic             sh2;
    logic [1:0]       serin2;
    logic [1:0]       serout2;
`endif

    int checks;
    int failures;

    int m_reg;
    int m_cnt;

    booth_shreg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .ld     (ld),
        .sh     (sh),
        .dir    (dir),
        .arith  (arith),
        .serin  (serin),
        .parin  (parin),
`ifdef SHREG_DUAL_SHIFT_EN
        .sh2    (sh2),
        .serin2 (serin2),
        .serout2(serout2),
`endif
        .parout (parout),
        .serout (serout),
        .cnt    (cnt),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the register value.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg <= 0;
            m_cnt <= 0;
        end else if (init) begin
            m_reg <= 0;
            m_cnt <= 0;
        end else if (ld) begin
            m_reg <= int'(parin);
            m_cnt <= 0;
        end else if (sh) begin
            if (dir)
                m_reg <= (m_reg * 2 + int'(serin)) % (1 << W);
            else if (arith)
                m_reg <= m_reg / 2 + ((m_reg >= (1 << (W - 1))) ? (1 << (W - 1)) : 0);
            else
                m_reg <= m_reg / 2 + int'(serin) * (1 << (W - 1));
            m_cnt <= (m_cnt + 1 > W) ? W : m_cnt + 1;
        end
    end

    // Compare process: mid-cycle, every cycle.
    always @(negedge clk) begin
        checkOutput("cyc_parout", int'(parout), m_reg);
        checkOutput("cyc_cnt", int'(cnt), m_cnt);
        checkOutput("cyc_done", int'(done), (m_cnt == W) ? 1 : 0);
        checkOutput("cyc_serout", int'(serout), dir ? ((m_reg >> (W - 1)) & 1) : (m_reg & 1));
    end

    task automatic applyStimulus(input logic i_init, input logic i_ld, input logic i_sh,
                                 input logic i_dir, input logic i_arith, input logic i_serin,
                                 input logic [W-1:0] i_parin);
        init  = i_init;
        ld    = i_ld;
        sh    = i_sh;
        dir   = i_dir;
        arith = i_arith;
        serin = i_serin;
        parin = i_parin;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef SHREG_DUAL_SHIFT_EN
        sh2    = 1'b0;
        serin2 = 2'b00;
`endif
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, '0);
        stepClock();
        checkOutput("reset_parout", int'(parout), 0);
        checkOutput("reset_cnt", int'(cnt), 0);
        checkOutput("reset_done", int'(done), 0);
        rst = 1'b1;

        // Asynchronous reset after loading all ones.
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b111111);
        stepClock();
        checkOutput("load_ones", int'(parout), 63);
        applyStimulus(0, 0, 0, 0, 0, 0, '0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_parout", int'(parout), 0);
        checkOutput("async_rst_cnt", int'(cnt), 0);
        checkOutput("async_rst_done", int'(done), 0);
        stepClock();
        rst = 1'b1;

        // Arithmetic right shift.
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b101100);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1, 1, '0);
        checkOutput("arith_serout_pre", int'(serout), 0);
        stepClock();
        checkOutput("arith_parout", int'(parout), 6'b110110);
        checkOutput("arith_cnt", int'(cnt), 1);

        // Logical right shifts.
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b101100);
        stepClock();
        applyStimulus(0, 0, 1, 0, 0, 1, '0);
        stepClock();
        checkOutput("logr_parout1", int'(parout), 6'b110110);
        applyStimulus(0, 0, 1, 0, 0, 0, '0);
        stepClock();
        checkOutput("logr_parout2", int'(parout), 6'b011011);
        checkOutput("logr_cnt2", int'(cnt), 2);

        // Hold: dir/arith/serin toggled without sh.
        applyStimulus(0, 0, 0, 1, 1, 1, 6'b111111);
        stepClock();
        checkOutput("hold_parout", int'(parout), 6'b011011);
        checkOutput("hold_cnt", int'(cnt), 2);

        // Left shift.
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b101100);
        stepClock();
        applyStimulus(0, 0, 1, 1, 1, 1, '0);
        checkOutput("left_serout_pre", int'(serout), 1);
        stepClock();
        checkOutput("left_parout", int'(parout), 6'b011001);

        // Counter saturation: six zero-fill right shifts, then a seventh with serin=1.
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b101100);
        stepClock();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, '0);
            stepClock();
            if (i == 5) begin
                checkOutput("sat_cnt5", int'(cnt), 5);
                checkOutput("sat_done5", int'(done), 0);
            end
        end
        checkOutput("sat_cnt6", int'(cnt), 6);
        checkOutput("sat_done6", int'(done), 1);
        applyStimulus(0, 0, 1, 0, 0, 1, '0);
        stepClock();
        checkOutput("sat_cnt7", int'(cnt), 6);
        checkOutput("sat_done7", int'(done), 1);
        checkOutput("sat_parout7", int'(parout), 6'b100000);
        applyStimulus(0, 1, 0, 0, 0, 0, 6'b010101);
        stepClock();
        checkOutput("sat_ld_cnt", int'(cnt), 0);
        checkOutput("sat_ld_done", int'(done), 0);

        // Priority: init beats ld and sh.
        applyStimulus(1, 1, 1, 0, 0, 1, 6'b111111);
        stepClock();
        checkOutput("prio_parout", int'(parout), 0);
        checkOutput("prio_cnt", int'(cnt), 0);

        // Priority: ld beats sh.
        applyStimulus(0, 1, 1, 1, 0, 1, 6'b100110);
        stepClock();
        checkOutput("ld_over_sh_parout", int'(parout), 6'b100110);
        checkOutput("ld_over_sh_cnt", int'(cnt), 0);

        // Random traffic with occasional mid-cycle asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          1'($urandom), W'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst = 1'b0;
                #1;
                checkOutput("rnd_async_parout", int'(parout), 0);
                checkOutput("rnd_async_cnt", int'(cnt), 0);
                stepClock();
                rst = 1'b1;
            end else begin
                stepClock();
            end
        end

        applyStimulus(0, 0, 0, 0, 0, 0, '0);
        stepClock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
